// File: rtl/usb_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_pkg
// Brief    : Shared types and constants for the USB transmit sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package usb_tx_pkg;

    // Packet sequencing states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        PID   = 3'd2,
        DATA  = 3'd3,
        CRC   = 3'd4,
        DRAIN = 3'd5,
        EOP   = 3'd6
    } state_t;

    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    localparam logic [3:0] ACK   = 4'b0010;
    localparam logic [3:0] NAK   = 4'b1010;
    localparam logic [3:0] DATA0 = 4'b0011;
    localparam logic [3:0] DATA1 = 4'b1011;

    // One serial CRC16 step: shift left, fold the polynomial in on feedback.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc16_serial.sv
`default_nettype none
// ============================================================================
// Module   : crc16_serial
// Brief    : Bit-serial CRC16 LFSR (poly 0x8005, init 0xFFFF).
// Revision : 1.0 - initial release
// ============================================================================
module crc16_serial
    import usb_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc_out
);

    // LFSR register: init has priority over a data step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_out <= CRC16_INIT;
        end else if (init) begin
            crc_out <= CRC16_INIT;
        end else if (en) begin
            crc_out <= crc16_step(crc_out, bit_in);
        end
    end

endmodule
`default_nettype wire

// File: rtl/usb_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_sequencer
// Brief    : Packet-level transmit controller feeding the bit stuffer:
//            SYNC, PID, optional payload + CRC16, drain, then EOP.
// Revision : 1.0 - initial release
// ============================================================================
module usb_tx_sequencer
    import usb_tx_pkg::*;
#(
    parameter int           DATA_BITS    = 64,
    parameter int           EOP_CYCLES   = 2,
    parameter logic [7:0]   SYNC_PATTERN = 8'b1000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_start,
    input  logic [3:0]           pkt_pid,
    input  logic                 pkt_has_data,
    input  logic [DATA_BITS-1:0] pkt_data,
    output logic                 busy,
    output logic                 done,
    output logic                 stuff_bit,
    output logic                 stuff_valid,
    input  logic                 stuff_ins,
    input  logic                 stuff_pending,
    output logic                 eop
);

    localparam logic [6:0] LAST_DATA = 7'(DATA_BITS - 1);
    localparam logic [6:0] LAST_EOP  = 7'(EOP_CYCLES - 1);

    state_t                 state;
    state_t                 state_nx;
    logic [6:0]             cnt;
    logic [3:0]             pid_q;
    logic                   has_data_q;
    logic [DATA_BITS-1:0]   data_sr;
    logic [15:0]            crc;
    logic                   crc_init;
    logic                   crc_en;

    // CRC restarts on every accepted packet and advances only on emitted payload bits
    assign crc_init = (state == IDLE) && pkt_start;
    assign crc_en   = (state == DATA) && stuff_valid;

    crc16_serial u_crc (
        .clk     (clk),
        .rst     (rst),
        .init    (crc_init),
        .en      (crc_en),
        .bit_in  (data_sr[0]),
        .crc_out (crc)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Bit/cycle counter: clears on any state change, holds on stuffer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 7'd0;
        end else if (state_nx != state) begin
            cnt <= 7'd0;
        end else if (stuff_valid || (state == EOP)) begin
            cnt <= cnt + 7'd1;
        end
    end

    // Descriptor capture on accept; payload shifts out LSB first on each emitted bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pid_q      <= 4'd0;
            has_data_q <= 1'b0;
            data_sr    <= '0;
        end else if ((state == IDLE) && pkt_start) begin
            pid_q      <= pkt_pid;
            has_data_q <= pkt_has_data;
            data_sr    <= pkt_data;
        end else if ((state == DATA) && stuff_valid) begin
            data_sr    <= {1'b0, data_sr[DATA_BITS-1:1]};
        end
    end

    // Next-state and output decode; a stalled cycle re-presents the same bit
    always_comb begin
        state_nx    = state;
        stuff_bit   = 1'b0;
        stuff_valid = 1'b0;
        done        = 1'b0;
        busy        = (state != IDLE);
        eop         = (state == EOP);
        case (state)
            IDLE: begin
                if (pkt_start) state_nx = SYNC;
            end
            SYNC: begin
                stuff_bit   = SYNC_PATTERN[cnt[2:0]];
                stuff_valid = !stuff_ins;
                if (stuff_valid && (cnt == 7'd7)) state_nx = PID;
            end
            PID: begin
                stuff_bit   = cnt[2] ? ~pid_q[cnt[1:0]] : pid_q[cnt[1:0]];
                stuff_valid = !stuff_ins;
                if (stuff_valid && (cnt == 7'd7)) state_nx = has_data_q ? DATA : DRAIN;
            end
            DATA: begin
                stuff_bit   = data_sr[0];
                stuff_valid = !stuff_ins;
                if (stuff_valid && (cnt == LAST_DATA)) state_nx = CRC;
            end
            CRC: begin
                stuff_bit   = ~crc[4'd15 - cnt[3:0]];
                stuff_valid = !stuff_ins;
                if (stuff_valid && (cnt == 7'd15)) state_nx = DRAIN;
            end
            DRAIN: begin
                if (!stuff_pending) state_nx = EOP;
            end
            EOP: begin
                if (cnt == LAST_EOP) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_tx_sequencer
// Brief    : Self-checking bench: a packet-level stream model predicts the
//            serial bit sequence and the drain/EOP/done timing each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_tx_sequencer;

    localparam int DATA_BITS  = 64;
    localparam int EOP_CYCLES = 2;

    typedef bit bitq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        pkt_start;
    logic [3:0]  pkt_pid;
    logic        pkt_has_data;
    logic [63:0] pkt_data;
    logic        busy;
    logic        done;
    logic        stuff_bit;
    logic        stuff_valid;
    logic        stuff_ins;
    logic        stuff_pending;
    logic        eop;

    always #5 clk = ~clk;

    usb_tx_sequencer #(
        .DATA_BITS    (DATA_BITS),
        .EOP_CYCLES   (EOP_CYCLES),
        .SYNC_PATTERN (8'b1000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pkt_start     (pkt_start),
        .pkt_pid       (pkt_pid),
        .pkt_has_data  (pkt_has_data),
        .pkt_data      (pkt_data),
        .busy          (busy),
        .done          (done),
        .stuff_bit     (stuff_bit),
        .stuff_valid   (stuff_valid),
        .stuff_ins     (stuff_ins),
        .stuff_pending (stuff_pending),
        .eop           (eop)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Reference CRC16 over the first n bits of d, bit 0 first
    function automatic logic [15:0] crc_model(input logic [63:0] d, input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
        return c;
    endfunction

    // Whole-packet serial stream in transmission order
    function automatic bitq_t build(input logic [3:0] pid, input bit has, input logic [63:0] d);
        bitq_t       q;
        logic [7:0]  sp;
        logic [15:0] c;
        sp = 8'b1000_0000;
        for (int i = 0; i < 8; i++) q.push_back(sp[i]);
        for (int i = 0; i < 4; i++) q.push_back(pid[i]);
        for (int i = 0; i < 4; i++) q.push_back(~pid[i]);
        if (has) begin
            for (int i = 0; i < DATA_BITS; i++) q.push_back(d[i]);
            c = crc_model(d, DATA_BITS);
            for (int i = 0; i < 16; i++) q.push_back(~c[15-i]);
        end
        return q;
    endfunction

    // Model state: 0 idle, 1 sending, 2 draining, 3 eop
    int    m_phase      = 0;
    bitq_t exp_q;
    int    eop_left     = 0;
    int    cyc          = 0;
    int    start_cyc    = 0;
    int    valid_cnt    = 0;
    int    drain_cnt    = 0;
    int    done_cnt     = 0;
    int    exp_valid    = -1;
    int    exp_drain    = -1;
    int    exp_done_lat = -1;
    int    pend_len     = 0;
    int    pend_cnt     = 0;
    int    ins_mode     = 0;
    int    ones_run     = 0;

    // Compare process: checks every output each cycle against the packet model
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("reset_outs", 64'({busy, done, stuff_bit, stuff_valid, eop}), 64'd0);
            m_phase  = 0;
            exp_q.delete();
            ones_run = 0;
            pend_cnt = 0;
        end else begin
            case (m_phase)
                0: begin
                    chk("idle_outs", 64'({busy, stuff_valid, eop, done}), 64'd0);
                    if (pkt_start) begin
                        exp_q     = build(pkt_pid, pkt_has_data, pkt_data);
                        m_phase   = 1;
                        start_cyc = cyc;
                        valid_cnt = 0;
                        drain_cnt = 0;
                    end
                end
                1: begin
                    chk("send_flags", 64'({busy, eop, done}), 64'(3'b100));
                    chk("stuff_valid", 64'(stuff_valid), 64'(!stuff_ins));
                    if (stuff_valid) begin
                        valid_cnt++;
                        chk("stuff_bit", 64'(stuff_bit), 64'(exp_q.pop_front()));
                        ones_run = stuff_bit ? ones_run + 1 : 0;
                        if (exp_q.size() == 0) begin
                            m_phase  = 2;
                            pend_cnt = pend_len;
                            if (exp_valid >= 0) chk("valid_count", 64'(valid_cnt), 64'(exp_valid));
                        end
                    end
                end
                2: begin
                    chk("drain_outs", 64'({busy, stuff_valid, eop, done}), 64'(4'b1000));
                    drain_cnt++;
                    if (!stuff_pending) begin
                        m_phase  = 3;
                        eop_left = EOP_CYCLES;
                        if (exp_drain >= 0) chk("drain_cycles", 64'(drain_cnt), 64'(exp_drain));
                    end
                end
                default: begin
                    chk("eop_outs", 64'({busy, stuff_valid, eop, done}),
                        64'({1'b1, 1'b0, 1'b1, (eop_left == 1)}));
                    if (done) done_cnt++;
                    eop_left--;
                    if (eop_left == 0) begin
                        m_phase = 0;
                        if (exp_done_lat >= 0) chk("done_latency", 64'(cyc - start_cyc), 64'(exp_done_lat));
                    end
                end
            endcase
        end
    end

    // Stuffer emulation: queue-pending after the last bit, and stall insertion
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pend_cnt > 0) begin
                stuff_pending = 1'b1;
                pend_cnt--;
            end else begin
                stuff_pending = 1'b0;
            end
            case (ins_mode)
                1: begin
                    if (ones_run >= 6) begin
                        stuff_ins = 1'b1;
                        ones_run  = 0;
                    end else begin
                        stuff_ins = 1'b0;
                    end
                end
                2:       stuff_ins = ($urandom_range(0, 3) == 0);
                default: stuff_ins = 1'b0;
            endcase
        end
    end

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (m_phase == 0) return;
        end
        timeout(name);
    endtask

    task automatic start_pkt(input logic [3:0] pid, input bit has, input logic [63:0] d);
        pkt_pid      = pid;
        pkt_has_data = has;
        pkt_data     = d;
        pkt_start    = 1'b1;
        @(posedge clk);
        #1;
        pkt_start    = 1'b0;
    endtask

    task automatic send(input logic [3:0] pid, input bit has, input logic [63:0] d, input string name);
        start_pkt(pid, has, d);
        wait_idle(name);
    endtask

    bitq_t       s;
    logic [15:0] pk;
    logic        orv;
    int          done_before;
    bit          hit;

    initial begin
        rst           = 1'b1;
        pkt_start     = 1'b0;
        pkt_pid       = 4'd0;
        pkt_has_data  = 1'b0;
        pkt_data      = 64'd0;
        stuff_ins     = 1'b0;
        stuff_pending = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Pin the model with hand-derived values
        s = build(4'b0010, 1'b0, 64'd0);
        chk("ack_stream_len", 64'(s.size()), 64'd16);
        pk = 16'd0;
        for (int i = 0; i < 16; i++) pk = {pk[14:0], s[i]};
        chk("ack_stream", 64'(pk), 64'h014B);
        chk("crc_model_one_zero", 64'(crc_model(64'd0, 1)), 64'h7FFB);
        chk("crc_model_one_one", 64'(crc_model(64'd1, 1)), 64'hFFFE);
        s = build(4'b0011, 1'b1, 64'd0);
        chk("data0_stream_len", 64'(s.size()), 64'd96);
        orv = 1'b0;
        for (int i = 16; i < 80; i++) orv = orv | s[i];
        chk("data0_payload_zero", 64'(orv), 64'd0);

        // ACK handshake: 16 bits, one drain cycle, two EOP cycles; done lands
        // 19 cycles after the start cycle (the 20th cycle counting it as first)
        exp_valid = 16; exp_drain = 1; exp_done_lat = 19;
        send(4'b0010, 1'b0, 64'd0, "ack_timeout");

        // DATA0 all zeros, no stalls
        exp_valid = 96; exp_drain = 1; exp_done_lat = 99;
        send(4'b0011, 1'b1, 64'd0, "data0_timeout");

        // DATA1 all ones with a stall after each run of six ones
        exp_done_lat = -1; ins_mode = 1;
        send(4'b1011, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, "data1_stall_timeout");
        ins_mode = 0;

        // Stuffer still draining for 5 cycles after the last CRC bit
        pend_len = 5; exp_drain = 6;
        send(4'b0011, 1'b1, {$urandom(), $urandom()}, "pending_timeout");
        pend_len = 0; exp_drain = 1;

        // Start request while in PID must be ignored
        done_before = done_cnt;
        exp_valid   = 16;
        start_pkt(4'b0010, 1'b0, 64'd0);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (m_phase == 1 && exp_q.size() <= 6) hit = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!hit) timeout("reach_pid");
        start_pkt(4'b1010, 1'b0, 64'd0);
        wait_idle("pid_start_timeout");
        repeat (3) @(posedge clk);
        #1;
        chk("single_done", 64'(done_cnt - done_before), 64'd1);

        // Asynchronous reset in the middle of the payload
        exp_valid = -1;
        start_pkt(4'b0011, 1'b1, {$urandom(), $urandom()});
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (m_phase == 1 && exp_q.size() <= 50) hit = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!hit) timeout("reach_data");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_reset_outs", 64'({busy, done, stuff_bit, stuff_valid, eop}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_valid = 96;
        send(4'b0011, 1'b1, {$urandom(), $urandom()}, "post_reset_timeout");

        // Randomized packets with random stalls and drain lengths
        exp_valid = -1; exp_drain = -1; ins_mode = 2;
        for (int n = 0; n < 20; n++) begin
            pend_len = $urandom_range(0, 4);
            send(4'(($urandom_range(0, 1) != 0) ? 4'b0011 : 4'b1011) ^ 4'(($urandom_range(0, 1) != 0) ? 4'b1001 : 4'b0000),
                 ($urandom_range(0, 1) != 0), {$urandom(), $urandom()}, "random_timeout");
        end
        ins_mode = 0; pend_len = 0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
